// File: rtl/multicycle_controller.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// multi-cycle multiply hold, memory-ack timeout and sticky error flags.
module multicycle_controller #(
   parameter int         MUL_LATENCY = 4,
   parameter int         MEM_TIMEOUT = 255,
   parameter logic [5:0] R_TYPE  = 6'h00,
   parameter logic [5:0] MADD_OP = 6'h1c,
   parameter logic [5:0] LW      = 6'h23,
   parameter logic [5:0] SW      = 6'h2b,
   parameter logic [5:0] BEQ     = 6'h04,
   parameter logic [5:0] BNE     = 6'h05,
   parameter logic [5:0] BGT     = 6'h07,
   parameter logic [5:0] BGTE    = 6'h01,
   parameter logic [5:0] BLEU    = 6'h16,
   parameter logic [5:0] BGTU    = 6'h17,
   parameter logic [5:0] J       = 6'h02,
   parameter logic [5:0] JAL     = 6'h03,
   parameter logic [5:0] ADDI    = 6'h08,
   parameter logic [5:0] ADDIU   = 6'h09,
   parameter logic [5:0] ANDI    = 6'h0c,
   parameter logic [5:0] ORI     = 6'h0d,
   parameter logic [5:0] XORI    = 6'h0e,
   parameter logic [5:0] SLTI    = 6'h0a,
   parameter logic [5:0] LUI     = 6'h0f,
   parameter logic [5:0] F_MUL   = 6'h18,
   parameter logic [5:0] F_JR    = 6'h08,
   parameter logic [5:0] F_MFHI  = 6'h10,
   parameter logic [5:0] F_MFLO  = 6'h12,
   parameter logic [5:0] F_SLL   = 6'h00,
   parameter logic [5:0] F_SRL   = 6'h02,
   parameter logic [5:0] F_SRA   = 6'h03
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        imem_ack,
   input  logic [31:0] inst,
   input  logic        dmem_ack,
   input  logic        alu_zero,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic [31:0] ir,
   output logic [5:0]  alu_op,
   output logic        alu_imm,
   output logic        reg_we,
   output logic [1:0]  reg_dst,
   output logic [2:0]  wb_src,
   output logic        hi_we,
   output logic        lo_we,
   output logic [2:0]  state,
   output logic        busy,
   output logic        illegal,
   output logic        timeout
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
      S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      C_ALU, C_MUL, C_JR, C_LW, C_SW, C_BR, C_J, C_JAL
   } cls_e;

   localparam logic [15:0] TO_LAST  = 16'(MEM_TIMEOUT - 1);
   localparam logic [4:0]  MUL_LAST = 5'(MUL_LATENCY - 1);

   state_e      state_q, state_d;
   cls_e        cls_q, cls_d, dec_cls;
   logic [31:0] ir_q, ir_d;
   logic [5:0]  alu_op_q, alu_op_d, dec_aop;
   logic        alu_imm_q, alu_imm_d, dec_imm, dec_ok;
   logic [1:0]  reg_dst_q, reg_dst_d, dec_dst;
   logic [2:0]  wb_src_q, wb_src_d, dec_wb;
   logic [4:0]  mcnt_q, mcnt_d;
   logic [15:0] wait_q, wait_d;
   logic        illegal_q, illegal_d, timeout_q, timeout_d;
   logic        run_q;
   logic        to_hit;
   logic [5:0]  op, fn;

   assign op = ir_q[31:26];
   assign fn = ir_q[5:0];

   always_comb begin
      dec_ok  = 1'b1;
      dec_cls = C_ALU;
      dec_aop = op;
      dec_imm = 1'b1;
      dec_dst = 2'd0;
      dec_wb  = 3'd0;
      if (op == R_TYPE) begin
         dec_aop = fn;
         dec_dst = 2'd1;
         dec_imm = (fn == F_SLL) || (fn == F_SRL) || (fn == F_SRA);
         if (fn == F_MUL)       dec_cls = C_MUL;
         else if (fn == F_JR)   dec_cls = C_JR;
         else if (fn == F_MFHI) dec_wb  = 3'd3;
         else if (fn == F_MFLO) dec_wb  = 3'd4;
      end else if (op == MADD_OP) begin
         dec_cls = C_MUL;
      end else if (op == LW) begin
         dec_cls = C_LW;
         dec_aop = ADDIU;
         dec_wb  = 3'd1;
      end else if (op == SW) begin
         dec_cls = C_SW;
         dec_aop = ADDIU;
      end else if (op == BEQ || op == BNE || op == BGT || op == BGTE ||
                   op == BLEU || op == BGTU) begin
         dec_cls = C_BR;
         dec_imm = 1'b0;
      end else if (op == J) begin
         dec_cls = C_J;
      end else if (op == JAL) begin
         dec_cls = C_JAL;
         dec_dst = 2'd2;
         dec_wb  = 3'd2;
      end else if (!(op == ADDI || op == ADDIU || op == ANDI || op == ORI ||
                     op == XORI || op == SLTI || op == LUI)) begin
         dec_ok = 1'b0;
      end
   end

   // Wait counter counts stalled request cycles; the last allowed one aborts.
   assign to_hit = (MEM_TIMEOUT != 0) && (wait_q == TO_LAST);

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      ir_d      = ir_q;
      alu_op_d  = alu_op_q;
      alu_imm_d = alu_imm_q;
      reg_dst_d = reg_dst_q;
      wb_src_d  = wb_src_q;
      mcnt_d    = mcnt_q;
      wait_d    = wait_q;
      illegal_d = illegal_q;
      timeout_d = timeout_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      reg_we    = 1'b0;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      unique case (state_q)
         S_FETCH: if (run_q) begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_d     = inst;
               pc_write = 1'b1;
               wait_d   = '0;
               state_d  = S_DECODE;
            end else if (to_hit) begin
               timeout_d = 1'b1;
               wait_d    = '0;
               state_d   = S_HALT;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         S_DECODE: begin
            if (dec_ok) begin
               cls_d     = dec_cls;
               alu_op_d  = dec_aop;
               alu_imm_d = dec_imm;
               reg_dst_d = dec_dst;
               wb_src_d  = dec_wb;
               mcnt_d    = '0;
               state_d   = S_EXEC;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_EXEC: begin
            unique case (cls_q)
               C_MUL: begin
                  if (mcnt_q == MUL_LAST) begin
                     mcnt_d  = '0;
                     state_d = S_WB;
                  end else begin
                     mcnt_d = mcnt_q + 5'd1;
                  end
               end
               C_BR:  begin pc_write = alu_zero; pc_src = 2'd1; state_d = S_FETCH; end
               C_J:   begin pc_write = 1'b1;     pc_src = 2'd2; state_d = S_FETCH; end
               C_JAL: begin pc_write = 1'b1;     pc_src = 2'd2; state_d = S_WB;    end
               C_JR:  begin pc_write = 1'b1;     pc_src = 2'd3; state_d = S_FETCH; end
               C_LW, C_SW: state_d = S_MEM;
               default:    state_d = S_WB;
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls_q == C_SW);
            if (dmem_ack) begin
               wait_d  = '0;
               state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
            end else if (to_hit) begin
               timeout_d = 1'b1;
               wait_d    = '0;
               state_d   = S_HALT;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         S_WB: begin
            reg_we  = (cls_q == C_ALU) || (cls_q == C_LW) || (cls_q == C_JAL);
            hi_we   = (cls_q == C_MUL);
            lo_we   = (cls_q == C_MUL);
            state_d = S_FETCH;
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         cls_q     <= C_ALU;
         ir_q      <= '0;
         alu_op_q  <= '0;
         alu_imm_q <= 1'b0;
         reg_dst_q <= '0;
         wb_src_q  <= '0;
         mcnt_q    <= '0;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         ir_q      <= ir_d;
         alu_op_q  <= alu_op_d;
         alu_imm_q <= alu_imm_d;
         reg_dst_q <= reg_dst_d;
         wb_src_q  <= wb_src_d;
         mcnt_q    <= mcnt_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
         run_q     <= 1'b1;
      end
   end

   assign ir      = ir_q;
   assign alu_op  = alu_op_q;
   assign alu_imm = alu_imm_q;
   assign reg_dst = reg_dst_q;
   assign wb_src  = wb_src_q;
   assign state   = state_q;
   assign busy    = (state_q != S_FETCH);
   assign illegal = illegal_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: expected strobe events are queued per instruction and a
// monitor pops them whenever the controller fires pc_write/reg_we/hi_we/lo_we.
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_ack, dmem_ack, alu_zero;
   logic [31:0] inst;
   logic        imem_req, dmem_req, dmem_we, pc_write, alu_imm, reg_we;
   logic        hi_we, lo_we, busy, illegal, timeout;
   logic [1:0]  pc_src, reg_dst;
   logic [2:0]  wb_src, state;
   logic [31:0] ir;
   logic [5:0]  alu_op;

   int errors = 0;
   int checks = 0;
   int idly = 0, ddly = 0, icnt = 0, dcnt = 0;

   typedef struct packed {
      logic [2:0] st;
      logic       pcw;
      logic [1:0] src;
      logic       rwe;
      logic [1:0] rdst;
      logic [2:0] wsrc;
      logic       hwe;
      logic       lwe;
      logic [5:0] aop;
   } ev_t;

   ev_t exp_q[$];
   ev_t act_ev, exp_ev;

   multicycle_controller #(.MUL_LATENCY(4), .MEM_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .imem_ack(imem_ack), .inst(inst),
      .dmem_ack(dmem_ack), .alu_zero(alu_zero), .imem_req(imem_req),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .pc_write(pc_write),
      .pc_src(pc_src), .ir(ir), .alu_op(alu_op), .alu_imm(alu_imm),
      .reg_we(reg_we), .reg_dst(reg_dst), .wb_src(wb_src), .hi_we(hi_we),
      .lo_we(lo_we), .state(state), .busy(busy), .illegal(illegal),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Memory responders: ack after a programmable number of stalled cycles.
   always_comb imem_ack = imem_req && (icnt >= idly);
   always_comb dmem_ack = dmem_req && (dcnt >= ddly);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         icnt <= 0;
         dcnt <= 0;
      end else begin
         icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
         dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
      end
   end

   always @(negedge clk) begin
      #1;
      if (rst_n && (pc_write || reg_we || hi_we || lo_we)) begin
         act_ev = '{state, pc_write, pc_src, reg_we,
                    (state == 3'd4) ? reg_dst : 2'd0,
                    (state == 3'd4) ? wb_src  : 3'd0,
                    hi_we, lo_we,
                    (state == 3'd4) ? alu_op  : 6'd0};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_event: unexpected event got %h", act_ev);
         end else begin
            exp_ev = exp_q.pop_front();
            if (act_ev !== exp_ev) begin
               errors++;
               $display("FAIL strobe_event: got %h expected %h at %0t", act_ev, exp_ev, $time);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [2:0] st, input logic pcw, input logic [1:0] src,
                       input logic rwe, input logic [1:0] rdst, input logic [2:0] wsrc,
                       input logic hl, input logic [5:0] aop);
      exp_q.push_back('{st, pcw, src, rwe, rdst, wsrc, hl, hl, aop});
   endtask

   task automatic push_fetch();
      push(3'd0, 1'b1, 2'd0, 1'b0, 2'd0, 3'd0, 1'b0, 6'd0);
   endtask

   // Runs one instruction from a FETCH cycle until FETCH returns or HALT.
   task automatic run_inst(input string nm, input logic [31:0] iw, input int id,
                           input int dd, input logic az, input int exp_tot,
                           input int exp_exec, input int exp_mem, input logic exp_we);
      int tot = 0, nexec = 0, nmem = 0;
      logic left = 1'b0, we_seen = 1'b0;
      inst = iw; idly = id; ddly = dd; alu_zero = az;
      for (int k = 0; k < 200; k++) begin
         if (state == 3'd5) break;
         if (state == 3'd0 && left) break;
         if (state != 3'd0) left = 1'b1;
         tot++;
         if (state == 3'd2) nexec++;
         if (state == 3'd3) begin nmem++; we_seen |= dmem_we; end
         @(negedge clk);
      end
      chk({nm, "_cycles"}, tot, exp_tot);
      if (exp_exec > 1) chk({nm, "_exec_cycles"}, nexec, exp_exec);
      if (exp_mem > 0) begin
         chk({nm, "_mem_cycles"}, nmem, exp_mem);
         chk({nm, "_dmem_we"}, {31'd0, we_seen}, {31'd0, exp_we});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; inst = 32'h00221821; alu_zero = 1'b0;
      #12;
      chk("rst_state", state, 0);
      chk("rst_ir", ir, 0);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      #1 chk("imem_req_before_edge", imem_req, 0);
      @(negedge clk);
      chk("imem_req_after_edge", imem_req, 1);

      push_fetch(); push(3'd4, 0, 0, 1, 2'd1, 3'd0, 0, 6'h21);
      run_inst("addu", 32'h00221821, 0, 0, 0, 4, 1, 0, 0);
      push_fetch(); push(3'd4, 0, 0, 1, 2'd0, 3'd1, 0, 6'h09);
      run_inst("lw", 32'h8C240008, 0, 3, 0, 8, 1, 4, 0);
      push_fetch(); push(3'd4, 0, 0, 1, 2'd0, 3'd0, 0, 6'h0d);
      run_inst("ori_wait", 32'h34220005, 2, 0, 0, 6, 1, 0, 0);
      push_fetch(); push(3'd2, 1, 2'd1, 0, 0, 0, 0, 0);
      run_inst("beq", 32'h10220003, 0, 0, 1, 3, 1, 0, 0);
      push_fetch();
      run_inst("bne", 32'h14220003, 0, 0, 0, 3, 1, 0, 0);
      push_fetch(); push(3'd4, 0, 0, 0, 2'd1, 3'd0, 1, 6'h18);
      run_inst("mul", 32'h00220018, 0, 0, 0, 7, 4, 0, 0);
      push_fetch(); push(3'd2, 1, 2'd2, 0, 0, 0, 0, 0);
      push(3'd4, 0, 0, 1, 2'd2, 3'd2, 0, 6'h03);
      run_inst("jal", 32'h0C000010, 0, 0, 0, 4, 1, 0, 0);
      push_fetch(); push(3'd4, 0, 0, 1, 2'd1, 3'd3, 0, 6'h10);
      run_inst("mfhi", 32'h00001810, 0, 0, 0, 4, 1, 0, 0);
      push_fetch(); push(3'd2, 1, 2'd3, 0, 0, 0, 0, 0);
      run_inst("jr", 32'h03E00008, 0, 0, 0, 3, 1, 0, 0);
      push_fetch();
      run_inst("sw", 32'hAC240008, 0, 1, 0, 5, 1, 2, 1);
      push_fetch(); push(3'd4, 0, 0, 0, 2'd0, 3'd0, 1, 6'h1c);
      run_inst("madd", 32'h70220000, 0, 0, 0, 7, 4, 0, 0);

      push_fetch();
      run_inst("illegal_op", 32'hFC000000, 0, 0, 0, 2, 0, 0, 0);
      chk("illegal_flag", illegal, 1);
      repeat (3) @(negedge clk);
      chk("halt_absorbing", state, 5);
      chk("halt_no_req", imem_req, 0);

      rst_n = 1'b0;
      #1 chk("illegal_cleared", illegal, 0);
      chk("reset_to_fetch", state, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      push_fetch();
      run_inst("sw_timeout", 32'hAC240008, 0, 1000, 0, 11, 1, 8, 1);
      chk("timeout_flag", timeout, 1);
      chk("timeout_state", state, 5);
      chk("timeout_dmem_req", dmem_req, 0);

      rst_n = 1'b0;
      #1 chk("timeout_cleared", timeout, 0);
      chk("timeout_reset_state", state, 0);
      inst = 32'h8C240008; idly = 0; ddly = 1000;
      #1 rst_n = 1'b1;
      push_fetch();
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         if (state == 3'd3) break;
         @(negedge clk);
      end
      chk("midmem_req_high", dmem_req, 1);
      #2 rst_n = 1'b0;
      #1 chk("midmem_req_async_drop", dmem_req, 0);
      chk("midmem_state", state, 0);
      idly = 1000;
      #1 rst_n = 1'b1;
      @(negedge clk);
      run_inst("fetch_timeout", 32'h00000000, 1000, 0, 0, 8, 0, 0, 0);
      chk("fetch_timeout_flag", timeout, 1);

      repeat (2) @(negedge clk);
      #2 chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
